// File: rtl/clk_gate_pkg.sv
// Shared types and default timing constants for the clock-gate controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_GATED  = 2'd1,
        ST_WAKING = 2'd2
    } gate_state_t;

    localparam int unsigned DEF_IDLE_THRESH = 16;
    localparam int unsigned DEF_WAKE_LAT    = 2;

endpackage

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock-gate enable controller with a wake-settle sequence and
// a saturating count of gated cycles.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_THRESH = DEF_IDLE_THRESH,
    parameter int unsigned WAKE_LAT    = DEF_WAKE_LAT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        busy_i,
    input  logic        sleep_req_i,
    input  logic        wake_req_i,
    input  logic        clr_cnt_i,
    output logic        clk_en_o,
    output logic        wake_ack_o,
    output logic        gated_o,
    output logic [31:0] gated_cnt_o
);

    localparam logic [15:0] IDLE_LAST = 16'(IDLE_THRESH - 1);
    localparam logic [3:0]  WAKE_LAST = (WAKE_LAT > 0) ? 4'(WAKE_LAT - 1) : 4'd0;

    gate_state_t state_q, state_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]  wake_cnt_q, wake_cnt_d;
    logic [31:0] gated_cnt_q;
    logic        wake_src;

    assign wake_src    = busy_i | wake_req_i;
    assign gated_cnt_o = gated_cnt_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        wake_cnt_d = '0;
        unique case (state_q)
            ST_ACTIVE: begin
                // Any wake source holds the idle count at zero and blocks gating.
                if (!wake_src) begin
                    if (sleep_req_i || idle_cnt_q == IDLE_LAST) state_d = ST_GATED;
                    else                                        idle_cnt_d = idle_cnt_q + 16'd1;
                end
            end
            ST_GATED: begin
                if (wake_src) state_d = (WAKE_LAT == 0) ? ST_ACTIVE : ST_WAKING;
            end
            ST_WAKING: begin
                if (wake_cnt_q == WAKE_LAST) state_d = ST_ACTIVE;
                else                         wake_cnt_d = wake_cnt_q + 4'd1;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers sample together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_ACTIVE;
            idle_cnt_q <= '0;
            wake_cnt_q <= '0;
            clk_en_o   <= 1'b1;
            gated_o    <= 1'b0;
            wake_ack_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            wake_cnt_q <= wake_cnt_d;
            // Status outputs are registered from the next state so they track state_q exactly.
            clk_en_o   <= (state_d != ST_GATED);
            gated_o    <= (state_d == ST_GATED);
            wake_ack_o <= (state_q == ST_ACTIVE) && wake_req_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                 gated_cnt_q <= '0;
        else if (clr_cnt_i)                        gated_cnt_q <= '0;
        else if (gated_o && gated_cnt_q != '1)     gated_cnt_q <= gated_cnt_q + 32'd1;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl at default parameters (IDLE_THRESH=16, WAKE_LAT=2).
module tb_clk_gate_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        busy_i, sleep_req_i, wake_req_i, clr_cnt_i;
    logic        clk_en_o, wake_ack_o, gated_o;
    logic [31:0] gated_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    clk_gate_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .busy_i      (busy_i),
        .sleep_req_i (sleep_req_i),
        .wake_req_i  (wake_req_i),
        .clr_cnt_i   (clr_cnt_i),
        .clk_en_o    (clk_en_o),
        .wake_ack_o  (wake_ack_o),
        .gated_o     (gated_o),
        .gated_cnt_o (gated_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1; busy_i = 1'b1; sleep_req_i = 1'b0; wake_req_i = 1'b0; clr_cnt_i = 1'b0;
        #2;
        check("rst_clk_en",    {31'd0, clk_en_o},   32'd1);
        check("rst_wake_ack",  {31'd0, wake_ack_o}, 32'd0);
        check("rst_gated",     {31'd0, gated_o},    32'd0);
        check("rst_gated_cnt", gated_cnt_o,         32'd0);
        tick(2);
        rst_i = 1'b0;
        tick(1);

        // Idle threshold expiry: busy falls at cycle 0, gated from cycle 16.
        busy_i = 1'b0;
        tick(15);
        check("idle_c15_clk_en", {31'd0, clk_en_o}, 32'd1);
        check("idle_c15_gated",  {31'd0, gated_o},  32'd0);
        tick(1);
        check("idle_c16_clk_en", {31'd0, clk_en_o}, 32'd0);
        check("idle_c16_gated",  {31'd0, gated_o},  32'd1);
        check("idle_c16_cnt",    gated_cnt_o,       32'd0);
        tick(10);
        check("gated_cnt_10",    gated_cnt_o,       32'd10);

        // Wake request from GATED with WAKE_LAT=2.
        wake_req_i = 1'b1;
        tick(1);
        check("wake_c1_clk_en", {31'd0, clk_en_o},   32'd1);
        check("wake_c1_gated",  {31'd0, gated_o},    32'd0);
        check("wake_c1_cnt",    gated_cnt_o,         32'd11);
        tick(2);
        check("wake_c3_ack",    {31'd0, wake_ack_o}, 32'd0);
        tick(1);
        check("wake_c4_ack",    {31'd0, wake_ack_o}, 32'd1);
        wake_req_i = 1'b0;
        tick(1);
        check("wake_drop_ack",  {31'd0, wake_ack_o}, 32'd0);
        check("wake_cnt_hold",  gated_cnt_o,         32'd11);

        // Busy pulse in the threshold cycle restarts the idle count.
        busy_i = 1'b1;
        tick(1);
        busy_i = 1'b0;
        tick(15);
        check("pulse_c15_clk_en", {31'd0, clk_en_o}, 32'd1);
        busy_i = 1'b1;
        tick(1);
        check("pulse_hold_clk_en", {31'd0, clk_en_o}, 32'd1);
        busy_i = 1'b0;
        tick(15);
        check("pulse_after15_clk_en", {31'd0, clk_en_o}, 32'd1);
        tick(1);
        check("pulse_after16_clk_en", {31'd0, clk_en_o}, 32'd0);
        check("pulse_after16_gated",  {31'd0, gated_o},  32'd1);

        // Saturation and clear-over-increment on the gated-cycle counter.
        dut.gated_cnt_q = 32'hFFFF_FFFD;
        tick(1);
        check("sat_fffe", gated_cnt_o, 32'hFFFF_FFFE);
        tick(1);
        check("sat_ffff", gated_cnt_o, 32'hFFFF_FFFF);
        tick(1);
        check("sat_hold", gated_cnt_o, 32'hFFFF_FFFF);
        clr_cnt_i = 1'b1;
        tick(1);
        check("clr_wins", gated_cnt_o, 32'd0);
        clr_cnt_i = 1'b0;
        tick(1);
        check("cnt_after_clr", gated_cnt_o, 32'd1);

        // Busy wakes; then wake beats sleep, and sleep alone gates at once.
        busy_i = 1'b1;
        tick(1);
        check("busy_wake_clk_en", {31'd0, clk_en_o}, 32'd1);
        tick(2);
        busy_i = 1'b0; sleep_req_i = 1'b1; wake_req_i = 1'b1;
        tick(1);
        check("both_clk_en", {31'd0, clk_en_o},   32'd1);
        check("both_ack",    {31'd0, wake_ack_o}, 32'd1);
        tick(1);
        check("both2_gated", {31'd0, gated_o},    32'd0);
        wake_req_i = 1'b0;
        tick(1);
        check("sleep_clk_en", {31'd0, clk_en_o},   32'd0);
        check("sleep_gated",  {31'd0, gated_o},    32'd1);
        check("sleep_ack",    {31'd0, wake_ack_o}, 32'd0);

        // Asynchronous reset in the middle of WAKING.
        sleep_req_i = 1'b0; wake_req_i = 1'b1;
        tick(1);
        check("pre_rst_clk_en", {31'd0, clk_en_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_clk_en", {31'd0, clk_en_o},   32'd1);
        check("mid_rst_gated",  {31'd0, gated_o},    32'd0);
        check("mid_rst_cnt",    gated_cnt_o,         32'd0);
        check("mid_rst_ack",    {31'd0, wake_ack_o}, 32'd0);
        wake_req_i = 1'b0;
        tick(1);
        rst_i = 1'b0;
        tick(15);
        check("post_rst_c15_clk_en", {31'd0, clk_en_o}, 32'd1);
        tick(1);
        check("post_rst_c16_clk_en", {31'd0, clk_en_o}, 32'd0);
        check("post_rst_c16_gated",  {31'd0, gated_o},  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_THRESH, default 16, meaning consecutive idle cycles before gating; legal range 1..65535.
REQ-002 SHALL have parameter WAKE_LAT, default 2, meaning enabled-clock settle cycles between ungating and ACTIVE; legal range 0..15.
REQ-003 SHALL have port clk_i, input, 1, free-running (ungated) clock.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port busy_i, input, 1, controlled domain has work pending; also a wake source.
REQ-006 SHALL have port sleep_req_i, input, 1, request immediate gating, bypassing the idle threshold.
REQ-007 SHALL have port wake_req_i, input, 1, level wake request; held until wake_ack_o is seen.
REQ-008 SHALL have port clr_cnt_i, input, 1, synchronous clear of gated_cnt_o.
REQ-009 SHALL have port clk_en_o, output, 1, registered enable to the clock-gate cell en_i.
REQ-010 SHALL have port wake_ack_o, output, 1, registered wake acknowledge.
REQ-011 SHALL have port gated_o, output, 1, registered status; high while in GATED.
REQ-012 SHALL have port gated_cnt_o, output, 32, cycles spent in GATED.

Function
REQ-013 SHALL implement FSM states ACTIVE, GATED, WAKING; clk_en_o = 0 only in GATED.
REQ-014 In ACTIVE, a 16-bit idle counter SHALL increment each cycle busy_i=0 and wake_req_i=0, and clear to 0 on any other cycle.
REQ-015 In ACTIVE, when idle counter = IDLE_THRESH-1 and busy_i=0 and wake_req_i=0, FSM SHALL enter GATED next cycle; busy_i falling at cycle 0 yields clk_en_o=0 from cycle IDLE_THRESH.
REQ-016 In ACTIVE, sleep_req_i=1 with busy_i=0 and wake_req_i=0 SHALL enter GATED next cycle regardless of the idle counter.
REQ-017 In GATED, busy_i=1 or wake_req_i=1 SHALL enter WAKING next cycle (ACTIVE directly when WAKE_LAT=0); clk_en_o=1 from that cycle.
REQ-018 WAKING SHALL last exactly WAKE_LAT cycles, counted by a 4-bit counter, then enter ACTIVE; inputs are ignored during WAKING.
REQ-019 wake_ack_o SHALL be 1 exactly on cycles following a cycle with state=ACTIVE and wake_req_i=1; it falls one cycle after wake_req_i drops.
REQ-020 wake_req_i=1 SHALL inhibit gating; wake wins over sleep_req_i and over idle-threshold expiry in the same cycle.
REQ-021 busy_i=1 in the threshold cycle SHALL keep ACTIVE and clear the idle counter.
REQ-022 Idle counter SHALL clear on every entry into ACTIVE.
REQ-023 gated_cnt_o SHALL increment by 1 each cycle gated_o=1, saturate at 32'hFFFF_FFFF, and clear on clr_cnt_i; clear wins over increment.

Reset
REQ-024 rst_i=1 SHALL asynchronously force ACTIVE, idle and wake counters 0, clk_en_o=1, wake_ack_o=0, gated_o=0, gated_cnt_o=0.
REQ-025 Reset asserted in GATED or WAKING SHALL restore clk_en_o=1 immediately without the WAKE_LAT sequence.

Structure
REQ-026 A shared package clk_gate_pkg SHALL hold the state enum typedef and default IDLE_THRESH/WAKE_LAT constants.
REQ-027 No sub-module; a single-always FSM plus counters; clk_en_o connects to the clock-gate cell en_i at integration level.

Verification
REQ-028 IDLE_THRESH=16: busy_i 1->0 at cycle 0, held 0 -> clk_en_o=0 and gated_o=1 at cycle 16; gated_cnt_o=10 after 10 more cycles.
REQ-029 IDLE_THRESH=16: busy_i pulses high at idle count 15 -> stays ACTIVE; gating occurs 16 cycles after the pulse ends.
REQ-030 WAKE_LAT=2, GATED: wake_req_i=1 at cycle 0 -> clk_en_o=1 at cycle 1, ACTIVE at cycle 3, wake_ack_o=1 at cycle 4; drop req -> ack=0 next cycle.
REQ-031 ACTIVE, busy_i=0: sleep_req_i and wake_req_i both 1 -> stays ACTIVE, ack asserted; sleep_req_i alone -> GATED next cycle.
REQ-032 rst_i asserted mid-WAKING -> clk_en_o=1, gated_cnt_o=0 immediately; after release, gating resumes after IDLE_THRESH idle cycles.
REQ-033 gated_cnt_o preloaded near 32'hFFFF_FFFF -> saturates at that value; clr_cnt_i coincident with increment -> 0.
